// File: rtl/display_scan_controller.sv
// display_scan_controller: scans a 4-digit common-anode 7-segment display
// through one shared hex decoder. Each digit slot is a BLANK dead-time
// followed by a SHOW window; host values are committed at frame start.
module display_scan_controller #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [3:0]  nibble,
    output logic        seg_blank,
    output logic [3:0]  an,
    output logic        dp,
    output logic        upd_pending
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Valid/ready does not apply here: load is a one-cycle strobe that is
    // always accepted; the shadow register absorbs it until the next commit.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit;
    logic [15:0]        shadow_q, shadow_d;
    logic [3:0]         sdp_q, sdp_d;
    logic [15:0]        disp_q, disp_d;
    logic [3:0]         ddp_q, ddp_d;
    logic               pend_q, pend_d;
    logic [3:0]         nibble_q, nibble_d;
    logic               seg_blank_q, seg_blank_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic               supp;
    logic [3:0]         an_act;
    logic               dp_act;

    // Next state: scan sequencing, with en=0 overriding everything to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    commit  = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            commit  = 1'b0;
        end
    end

    // Shadow capture and frame-boundary commit; a load in the commit cycle
    // flows straight through because commit copies the updated shadow.
    always_comb begin
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        disp_d   = disp_q;
        ddp_d    = ddp_q;
        pend_d   = pend_q;
        if (load) begin
            shadow_d = data_in;
            sdp_d    = dp_in;
            pend_d   = 1'b1;
        end
        if (commit) begin
            disp_d = shadow_d;
            ddp_d  = sdp_d;
            pend_d = 1'b0;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        nibble_d    = 4'd0;
        seg_blank_d = 1'b1;
        an_act      = 4'd0;
        dp_act      = 1'b0;
        case (idx_d)
            2'd3:    supp = lz_blank && (disp_d[15:12] == 4'd0);
            2'd2:    supp = lz_blank && (disp_d[15:8] == 8'd0);
            2'd1:    supp = lz_blank && (disp_d[15:4] == 12'd0);
            default: supp = 1'b0;
        endcase
        if (state_d != ST_IDLE) begin
            case (idx_d)
                2'd0:    nibble_d = disp_d[3:0];
                2'd1:    nibble_d = disp_d[7:4];
                2'd2:    nibble_d = disp_d[11:8];
                default: nibble_d = disp_d[15:12];
            endcase
        end
        if (state_d == ST_SHOW && !supp) begin
            an_act      = 4'b0001 << idx_d;
            seg_blank_d = 1'b0;
            dp_act      = ddp_d[idx_d];
        end
        an_d = an_act ^ {4{ACTIVE_LOW}};
        dp_d = dp_act ^ ACTIVE_LOW;
    end

    // State, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            shadow_q    <= 16'd0;
            sdp_q       <= 4'd0;
            disp_q      <= 16'd0;
            ddp_q       <= 4'd0;
            pend_q      <= 1'b0;
            nibble_q    <= 4'd0;
            seg_blank_q <= 1'b1;
            an_q        <= {4{ACTIVE_LOW}};
            dp_q        <= ACTIVE_LOW;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            disp_q      <= disp_d;
            ddp_q       <= ddp_d;
            pend_q      <= pend_d;
            nibble_q    <= nibble_d;
            seg_blank_q <= seg_blank_d;
            an_q        <= an_d;
            dp_q        <= dp_d;
        end
    end

    assign nibble      = nibble_q;
    assign seg_blank   = seg_blank_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: frame-position model plus directed
// literal checks at hand-picked points of the scan.
module tb_display_scan_controller;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int PER   = DC + BC;
  localparam int FRAME = 4 * PER;

  logic        clk = 1'b0;
  logic        rst, en, load, lz_blank;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  nibble, an;
  logic        seg_blank, dp, upd_pending;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  bit          m_run;
  int          m_pos;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic [3:0]  e_nibble, e_an;
  logic        e_seg, e_dp;

  display_scan_controller #(
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .load(load),
    .dp_in(dp_in), .lz_blank(lz_blank), .nibble(nibble),
    .seg_blank(seg_blank), .an(an), .dp(dp), .upd_pending(upd_pending)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_commit();
    m_disp = m_shadow;
    m_ddp  = m_sdp;
    m_pend = 1'b0;
  endtask

  // model: position inside the frame decides everything
  always @(posedge clk) begin
    int digit, off;
    bit supp;
    if (rst) begin
      m_run = 0; m_pos = 0; m_shadow = 0; m_sdp = 0;
      m_disp = 0; m_ddp = 0; m_pend = 0;
    end else begin
      if (load) begin
        m_shadow = data_in;
        m_sdp    = dp_in;
        m_pend   = 1'b1;
      end
      if (!en) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0;
        do_commit();
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0) do_commit();
      end
    end
    e_an = 4'b1111; e_seg = 1'b1; e_dp = 1'b1; e_nibble = 4'd0;
    if (m_run) begin
      digit    = m_pos / PER;
      off      = m_pos % PER;
      e_nibble = 4'((m_disp >> (4 * digit)) & 16'hF);
      supp     = lz_blank && digit > 0 && ((m_disp >> (4 * digit)) == 16'd0);
      if (off >= BC && !supp) begin
        e_an  = ~(4'b0001 << digit);
        e_seg = 1'b0;
        e_dp  = ~m_ddp[digit];
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_nibble", {12'd0, nibble}, {12'd0, e_nibble});
      chk("cyc_an", {12'd0, an}, {12'd0, e_an});
      chk("cyc_seg_blank", {15'd0, seg_blank}, {15'd0, e_seg});
      chk("cyc_dp", {15'd0, dp}, {15'd0, e_dp});
      chk("cyc_upd_pending", {15'd0, upd_pending}, {15'd0, m_pend});
    end
  end

  task automatic wait_pos(input int p);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (m_run && m_pos == p) return;
    end
    total++;
    bad++;
    $display("FAIL wait_pos: position %0d not reached, got %0d", p, m_pos);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
    data_in = 16'd0; dp_in = 4'd0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_seg", {15'd0, seg_blank}, 16'd1);
    chk("rst_nibble", {12'd0, nibble}, 16'd0);
    chk("rst_pend", {15'd0, upd_pending}, 16'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // first frame shows old value, second frame 1A2F
    en = 1'b1;
    @(negedge clk);
    do_load(16'h1A2F, 4'd0);
    wait_pos(2);
    chk("f1_nibble", {12'd0, nibble}, 16'h0);
    chk("f1_an", {12'd0, an}, 16'hE);
    chk("f1_pend", {15'd0, upd_pending}, 16'd1);
    wait_pos(0);
    chk("f2_pend", {15'd0, upd_pending}, 16'd0);
    wait_pos(2);
    chk("d0_nibble", {12'd0, nibble}, 16'hF);
    chk("d0_an", {12'd0, an}, 16'hE);
    wait_pos(10);
    chk("blank_an", {12'd0, an}, 16'hF);
    chk("blank_nibble", {12'd0, nibble}, 16'h2);
    wait_pos(12);
    chk("d1_nibble", {12'd0, nibble}, 16'h2);
    chk("d1_an", {12'd0, an}, 16'hD);
    wait_pos(22);
    chk("d2_nibble", {12'd0, nibble}, 16'hA);
    chk("d2_an", {12'd0, an}, 16'hB);
    wait_pos(32);
    chk("d3_nibble", {12'd0, nibble}, 16'h1);
    chk("d3_an", {12'd0, an}, 16'h7);

    // leading-zero suppression
    lz_blank = 1'b1;
    do_load(16'h0050, 4'd0);
    wait_pos(0);
    wait_pos(2);
    chk("lz_d0_nibble", {12'd0, nibble}, 16'h0);
    chk("lz_d0_an", {12'd0, an}, 16'hE);
    wait_pos(12);
    chk("lz_d1_nibble", {12'd0, nibble}, 16'h5);
    chk("lz_d1_an", {12'd0, an}, 16'hD);
    wait_pos(22);
    chk("lz_d2_an", {12'd0, an}, 16'hF);
    chk("lz_d2_seg", {15'd0, seg_blank}, 16'd1);
    wait_pos(32);
    chk("lz_d3_an", {12'd0, an}, 16'hF);
    do_load(16'h0000, 4'd0);
    wait_pos(0);
    wait_pos(2);
    chk("lz0_d0_an", {12'd0, an}, 16'hE);
    chk("lz0_d0_seg", {15'd0, seg_blank}, 16'd0);
    wait_pos(12);
    chk("lz0_d1_an", {12'd0, an}, 16'hF);
    lz_blank = 1'b0;

    // multiple loads, last one in the commit cycle
    wait_pos(5);
    do_load(16'h1111, 4'd0);
    wait_pos(15);
    do_load(16'h2222, 4'd0);
    wait_pos(39);
    chk("ml_pend_before", {15'd0, upd_pending}, 16'd1);
    do_load(16'h3333, 4'd0);
    chk("ml_pend_after", {15'd0, upd_pending}, 16'd0);
    wait_pos(2);
    chk("ml_nibble", {12'd0, nibble}, 16'h3);

    // decimal point and en drop during digit 2
    do_load(16'h1234, 4'b0100);
    wait_pos(0);
    wait_pos(15);
    chk("dp_d1", {15'd0, dp}, 16'd1);
    wait_pos(25);
    chk("dp_d2", {15'd0, dp}, 16'd0);
    chk("dp_d2_an", {12'd0, an}, 16'hB);
    chk("dp_d2_nibble", {12'd0, nibble}, 16'h2);
    en = 1'b0;
    @(negedge clk);
    chk("off_an", {12'd0, an}, 16'hF);
    chk("off_seg", {15'd0, seg_blank}, 16'd1);
    do_load(16'h4321, 4'd0);
    chk("off_pend", {15'd0, upd_pending}, 16'd1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_pend", {15'd0, upd_pending}, 16'd0);
    wait_pos(2);
    chk("reen_nibble", {12'd0, nibble}, 16'h1);
    chk("reen_dp", {15'd0, dp}, 16'd1);

    // reset mid-scan with a pending load
    wait_pos(10);
    do_load(16'h9999, 4'hF);
    wait_pos(15);
    chk("pre_rst_pend", {15'd0, upd_pending}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_an", {12'd0, an}, 16'hF);
    chk("mrst_nibble", {12'd0, nibble}, 16'h0);
    chk("mrst_pend", {15'd0, upd_pending}, 16'd0);
    chk("mrst_seg", {15'd0, seg_blank}, 16'd1);
    rst = 1'b0;
    wait_pos(2);
    chk("post_rst_nibble", {12'd0, nibble}, 16'h0);
    chk("post_rst_an", {12'd0, an}, 16'hE);
    wait_pos(12);
    chk("post_rst_d1", {12'd0, nibble}, 16'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
